banked_reg_file: RTL and testbench

BANKED_REG_FILE -- requirements
Module: banked_reg_file

---
 rtl/banked_reg_file_if.sv | 43 ++++
 rtl/banked_reg_file.sv | 107 ++++++++++
 tb/tb_banked_reg_file.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_reg_file_if.sv
// Bus bundle for banked_reg_file: mode, three read ports,
// two write ports, PC control and clear-sweep status.
interface banked_reg_file_if #(
    parameter int ADDR = 4,
    parameter int SIZE = 32
);
    logic [4:0]      Mode;
    logic [ADDR-1:0] R_Addr_A;
    logic [ADDR-1:0] R_Addr_B;
    logic [ADDR-1:0] R_Addr_C;
    logic            Write_Reg;
    logic [ADDR-1:0] W_Addr;
    logic [SIZE-1:0] W_Data;
    logic            Write_Reg_B;
    logic [ADDR-1:0] W_Addr_B;
    logic [SIZE-1:0] W_Data_B;
    logic            PC_Inc;
    logic            Clr;
    logic [SIZE-1:0] R_Data_A;
    logic [SIZE-1:0] R_Data_B;
    logic [SIZE-1:0] R_Data_C;
    logic [SIZE-1:0] PC_Out;
    logic            Busy;
    logic            Mode_Err;

    modport master (
        output Mode, R_Addr_A, R_Addr_B, R_Addr_C,
        output Write_Reg, W_Addr, W_Data,
        output Write_Reg_B, W_Addr_B, W_Data_B,
        output PC_Inc, Clr,
        input  R_Data_A, R_Data_B, R_Data_C,
        input  PC_Out, Busy, Mode_Err
    );

    modport slave (
        input  Mode, R_Addr_A, R_Addr_B, R_Addr_C,
        input  Write_Reg, W_Addr, W_Data,
        input  Write_Reg_B, W_Addr_B, W_Data_B,
        input  PC_Inc, Clr,
        output R_Data_A, R_Data_B, R_Data_C,
        output PC_Out, Busy, Mode_Err
    );
endinterface

// File: rtl/banked_reg_file.sv
// ARM-style banked register file: 31 physical registers, 16 visible
// per mode, dual write ports, auto-increment PC and a clear sweep.
module banked_reg_file #(
    parameter int ADDR    = 4,
    parameter int SIZE    = 32,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               Rst_n,
    banked_reg_file_if.slave   bus
);
    localparam int NPHYS = 31;
    localparam logic [4:0] PC_IDX = 5'd30;

    logic [SIZE-1:0] regs_q [NPHYS];
    logic [SIZE-1:0] regs_d [NPHYS];
    logic            busy_q, busy_d;
    logic [4:0]      idx_q, idx_d;
    logic [4:0]      pa, pb;

    function automatic logic mode_legal(input logic [4:0] m);
        logic ok;
        case (m)
            5'b10000, 5'b10001, 5'b10010, 5'b10011,
            5'b10111, 5'b11011, 5'b11111: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Bank 0 is USR/SYS and also absorbs illegal modes.
    function automatic logic [4:0] phys(
        input logic [4:0]      m,
        input logic [ADDR-1:0] a
    );
        logic [2:0] bank;
        logic [4:0] r;
        case (m)
            5'b10001: bank = 3'd1;
            5'b10010: bank = 3'd2;
            5'b10011: bank = 3'd3;
            5'b10111: bank = 3'd4;
            5'b11011: bank = 3'd5;
            default:  bank = 3'd0;
        endcase
        if (a == ADDR'(15))
            r = PC_IDX;
        else if (a < ADDR'(8))
            r = 5'(a);
        else if (a < ADDR'(13))
            r = (bank == 3'd1) ? 5'(a) + 5'd5 : 5'(a);
        else
            r = 5'd18 + {1'b0, bank, 1'b0} + 5'(a - ADDR'(13));
        return r;
    endfunction

    assign pa = phys(bus.Mode, bus.W_Addr);
    assign pb = phys(bus.Mode, bus.W_Addr_B);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        idx_d  = idx_q;
        if (busy_q) begin
            regs_d[idx_q] = '0;
            if (idx_q == PC_IDX) begin
                busy_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end else if (bus.Clr) begin
            busy_d = 1'b1;
            idx_d  = '0;
        end else begin
            // Port A is applied last so it wins a shared target.
            if (bus.Write_Reg_B)
                regs_d[pb] = bus.W_Data_B;
            if (bus.Write_Reg)
                regs_d[pa] = bus.W_Data;
            if (bus.PC_Inc &&
                !(bus.Write_Reg && pa == PC_IDX) &&
                !(bus.Write_Reg_B && pb == PC_IDX))
                regs_d[PC_IDX] = regs_q[PC_IDX] + SIZE'(PC_STEP);
        end
    end

    always_ff @(negedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NPHYS; i++)
                regs_q[i] <= '0;
            busy_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            idx_q  <= idx_d;
        end
    end

    assign bus.R_Data_A = regs_q[phys(bus.Mode, bus.R_Addr_A)];
    assign bus.R_Data_B = regs_q[phys(bus.Mode, bus.R_Addr_B)];
    assign bus.R_Data_C = regs_q[phys(bus.Mode, bus.R_Addr_C)];
    assign bus.PC_Out   = regs_q[PC_IDX];
    assign bus.Busy     = busy_q;
    assign bus.Mode_Err = !mode_legal(bus.Mode);
endmodule

// File: tb/tb_banked_reg_file.sv
// Self-checking bench for banked_reg_file: vector table for banking,
// hand sequences for collisions, PC, clear sweep and reset.
module tb_banked_reg_file;
    localparam logic [4:0] USR = 5'b10000;
    localparam logic [4:0] FIQ = 5'b10001;
    localparam logic [4:0] IRQ = 5'b10010;
    localparam logic [4:0] SVC = 5'b10011;
    localparam logic [4:0] ABT = 5'b10111;
    localparam logic [4:0] UND = 5'b11011;
    localparam logic [4:0] SYS = 5'b11111;

    logic clk = 1'b0;
    logic Rst_n;

    banked_reg_file_if #(.ADDR(4), .SIZE(32)) bus ();

    banked_reg_file #(.ADDR(4), .SIZE(32), .PC_STEP(4)) dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  mode;
        logic        wr;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    task automatic push(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h, no expected value queued", name, act);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, act, exp);
            end
        end
    endtask

    task automatic idle();
        bus.Write_Reg   = 1'b0;
        bus.Write_Reg_B = 1'b0;
        bus.PC_Inc      = 1'b0;
        bus.Clr         = 1'b0;
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] m, input logic [3:0] a,
                      input logic [31:0] d);
        @(posedge clk);
        idle();
        bus.Mode      = m;
        bus.W_Addr    = a;
        bus.W_Data    = d;
        bus.Write_Reg = 1'b1;
        fall();
        idle();
    endtask

    task automatic rd(input logic [4:0] m, input logic [3:0] a,
                      output logic [31:0] q);
        bus.Mode     = m;
        bus.R_Addr_A = a;
        #1;
        q = bus.R_Data_A;
    endtask

    function automatic logic [31:0] val(input logic [4:0] m,
                                        input logic [3:0] a);
        return 32'hC000_0000 | (32'(m) << 8) | 32'(a);
    endfunction

    // Every one of the 31 physical registers gets a nonzero value.
    task automatic fill();
        for (int a = 0; a < 16; a++)
            wr(USR, 4'(a), val(USR, 4'(a)));
        for (int a = 8; a < 15; a++)
            wr(FIQ, 4'(a), val(FIQ, 4'(a)));
        for (int a = 13; a < 15; a++) begin
            wr(IRQ, 4'(a), val(IRQ, 4'(a)));
            wr(SVC, 4'(a), val(SVC, 4'(a)));
            wr(ABT, 4'(a), val(ABT, 4'(a)));
            wr(UND, 4'(a), val(UND, 4'(a)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        int n;

        vecs[0]  = '{SVC, 1'b1, 4'd13, 32'h1111,     4'd13, 32'h1111};
        vecs[1]  = '{IRQ, 1'b1, 4'd13, 32'h2222,     4'd13, 32'h2222};
        vecs[2]  = '{SVC, 1'b0, 4'd0,  32'h0,        4'd13, 32'h1111};
        vecs[3]  = '{USR, 1'b0, 4'd0,  32'h0,        4'd13, 32'h0};
        vecs[4]  = '{SYS, 1'b1, 4'd13, 32'h3333,     4'd13, 32'h3333};
        vecs[5]  = '{USR, 1'b0, 4'd0,  32'h0,        4'd13, 32'h3333};
        vecs[6]  = '{USR, 1'b1, 4'd8,  32'hA5A5A5A5, 4'd8,  32'hA5A5A5A5};
        vecs[7]  = '{FIQ, 1'b1, 4'd8,  32'h5A5A5A5A, 4'd8,  32'h5A5A5A5A};
        vecs[8]  = '{USR, 1'b0, 4'd0,  32'h0,        4'd8,  32'hA5A5A5A5};
        vecs[9]  = '{FIQ, 1'b1, 4'd7,  32'h77,       4'd7,  32'h77};
        vecs[10] = '{USR, 1'b0, 4'd0,  32'h0,        4'd7,  32'h77};
        vecs[11] = '{ABT, 1'b1, 4'd14, 32'hABAB,     4'd14, 32'hABAB};
        vecs[12] = '{UND, 1'b0, 4'd0,  32'h0,        4'd14, 32'h0};

        bus.Mode = USR;
        bus.R_Addr_A = '0;
        bus.R_Addr_B = '0;
        bus.R_Addr_C = '0;
        bus.W_Addr = '0;
        bus.W_Data = '0;
        bus.W_Addr_B = '0;
        bus.W_Data_B = '0;
        idle();
        Rst_n = 1'b0;
        #3;
        push(0); check("reset busy", 32'(bus.Busy));
        push(0); check("reset pc", bus.PC_Out);
        push(0); check("reset r0", bus.R_Data_A);
        #9 Rst_n = 1'b1;
        fall();
        push(0); check("first edge busy", 32'(bus.Busy));

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            idle();
            bus.Mode      = vecs[i].mode;
            bus.Write_Reg = vecs[i].wr;
            bus.W_Addr    = vecs[i].wa;
            bus.W_Data    = vecs[i].wd;
            bus.R_Addr_A  = vecs[i].ra;
            bus.R_Addr_B  = vecs[i].ra;
            bus.R_Addr_C  = vecs[i].ra;
            push(vecs[i].exp);
            push(vecs[i].exp);
            push(vecs[i].exp);
            push(0);
            fall();
            check($sformatf("vec%0d rdA", i), bus.R_Data_A);
            check($sformatf("vec%0d rdB", i), bus.R_Data_B);
            check($sformatf("vec%0d rdC", i), bus.R_Data_C);
            check($sformatf("vec%0d mode_err", i), 32'(bus.Mode_Err));
            idle();
        end

        @(posedge clk);
        bus.Mode = USR;
        bus.Write_Reg = 1'b1; bus.W_Addr = 4'd3; bus.W_Data = 32'h10;
        bus.Write_Reg_B = 1'b1; bus.W_Addr_B = 4'd3; bus.W_Data_B = 32'h20;
        fall();
        idle();
        push(32'h10); rd(USR, 4'd3, q); check("collision r3", q);
        @(posedge clk);
        bus.Write_Reg = 1'b1; bus.W_Addr = 4'd3; bus.W_Data = 32'h30;
        bus.Write_Reg_B = 1'b1; bus.W_Addr_B = 4'd4; bus.W_Data_B = 32'h40;
        bus.R_Addr_A = 4'd3; bus.R_Addr_B = 4'd4;
        fall();
        idle();
        push(32'h30); check("dual r3", bus.R_Data_A);
        push(32'h40); check("dual r4", bus.R_Data_B);

        wr(USR, 4'd15, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC); check("pc write", bus.PC_Out);
        @(posedge clk); bus.PC_Inc = 1'b1; fall(); idle();
        push(0); check("pc wrap", bus.PC_Out);
        @(posedge clk);
        bus.PC_Inc = 1'b1;
        bus.Write_Reg = 1'b1; bus.W_Addr = 4'd15; bus.W_Data = 32'h100;
        bus.R_Addr_C = 4'd15;
        fall(); idle();
        push(32'h100); check("pc write over inc", bus.PC_Out);
        push(32'h100); check("r15 read", bus.R_Data_C);
        @(posedge clk); bus.PC_Inc = 1'b1; fall(); idle();
        push(32'h104); check("pc inc", bus.PC_Out);
        @(posedge clk);
        bus.PC_Inc = 1'b1;
        bus.Write_Reg_B = 1'b1; bus.W_Addr_B = 4'd15; bus.W_Data_B = 32'h200;
        fall(); idle();
        push(32'h200); check("pc port b over inc", bus.PC_Out);

        fill();
        @(posedge clk);
        bus.Mode = USR;
        bus.Clr = 1'b1; bus.PC_Inc = 1'b1;
        bus.Write_Reg = 1'b1; bus.W_Addr = 4'd2; bus.W_Data = 32'hDEAD;
        bus.R_Addr_A = 4'd2;
        fall(); idle();
        push(1); check("clr busy", 32'(bus.Busy));
        push(val(USR, 4'd2)); check("clr edge write lost", bus.R_Data_A);
        push(val(USR, 4'd15)); check("clr edge pc held", bus.PC_Out);
        bus.R_Addr_A = 4'd0;
        bus.R_Addr_B = 4'd1;
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            @(posedge clk);
            idle();
            if (n == 4) begin
                bus.Write_Reg = 1'b1; bus.W_Addr = 4'd0; bus.W_Data = 32'hFFFF;
                bus.Write_Reg_B = 1'b1; bus.W_Addr_B = 4'd1;
                bus.W_Data_B = 32'hEEEE;
                bus.PC_Inc = 1'b1; bus.Clr = 1'b1;
            end
            fall();
            n++;
            if (n == 1) begin
                push(0); check("sweep r0 cleared", bus.R_Data_A);
                push(val(USR, 4'd1)); check("sweep r1 pending", bus.R_Data_B);
            end
        end
        idle();
        push(31); check("sweep busy edges", 32'(n));
        for (int a = 0; a < 16; a++) begin
            push(0); rd(USR, 4'(a), q); check($sformatf("swept usr r%0d", a), q);
        end
        for (int a = 8; a < 15; a++) begin
            push(0); rd(FIQ, 4'(a), q); check($sformatf("swept fiq r%0d", a), q);
        end
        for (int a = 13; a < 15; a++) begin
            push(0); rd(IRQ, 4'(a), q); check("swept irq", q);
            push(0); rd(SVC, 4'(a), q); check("swept svc", q);
            push(0); rd(ABT, 4'(a), q); check("swept abt", q);
            push(0); rd(UND, 4'(a), q); check("swept und", q);
        end
        fall();
        push(0); check("sweep not restarted", 32'(bus.Busy));

        fill();
        @(posedge clk); bus.Clr = 1'b1; fall(); idle();
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 Rst_n = 1'b0;
        bus.Mode = 5'b00000;
        bus.R_Addr_A = 4'd12;
        #1;
        push(0); check("rst busy", 32'(bus.Busy));
        push(0); check("rst pc", bus.PC_Out);
        push(0); check("rst r12", bus.R_Data_A);
        push(1); check("rst mode_err", 32'(bus.Mode_Err));
        push(0); rd(UND, 4'd13, q); check("rst und r13", q);
        #1 Rst_n = 1'b1;
        fall();
        push(0); check("post rst busy", 32'(bus.Busy));

        wr(5'b00000, 4'd13, 32'h4444);
        push(1); check("illegal mode_err", 32'(bus.Mode_Err));
        push(32'h4444); rd(USR, 4'd13, q); check("illegal as usr", q);
        push(0); check("usr mode_err", 32'(bus.Mode_Err));
        push(32'h4444); rd(SYS, 4'd13, q); check("illegal as sys", q);
        push(0); rd(FIQ, 4'd13, q); check("illegal not fiq", q);
        bus.Mode = 5'b10100;
        #1;
        push(1); check("mode_err 10100", 32'(bus.Mode_Err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
